// File: rtl/pixel_seq.sv
// Frame capture sequencer for a pointer-addressed pixel sensor: walks rows/columns,
// triggers the ADC per pixel and pushes results to a FIFO. Optional macro: PIXEL_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module pixel_seq #(
   parameter int PULSE_W     = 2,
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic       CLK50,
   input  logic       RST,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] rows,
   input  logic [7:0] cols,
   input  logic       adc_done,
   input  logic [9:0] adc_data,
   input  logic       fifo_full,
   output logic       resp,
   output logic       incp,
   output logic       resv,
   output logic       incv,
   output logic       inphi,
   output logic       adc_start,
   output logic       fifo_wren,
   output logic [9:0] fifo_wdata,
   output logic       busy,
   output logic       done,
   output logic       err
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_VRST   = 3'd1;
   localparam logic [2:0] S_PRST   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_CONV   = 3'd4;
   localparam logic [2:0] S_WRITE  = 3'd5;
   localparam logic [2:0] S_INCP   = 3'd6;
   localparam logic [2:0] S_INCV   = 3'd7;

   localparam logic [7:0] PW_LAST     = 8'(PULSE_W - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

   logic [2:0] r_state;
   logic [7:0] r_cnt;
   logic [7:0] r_row;
   logic [7:0] r_col;
   logic [7:0] r_rows;
   logic [7:0] r_cols;
   logic [9:0] r_data;
   logic       r_resp, r_incp, r_resv, r_incv, r_inphi;
   logic       r_adc_start, r_fifo_wren, r_busy, r_done;
   logic [9:0] r_fifo_wdata;

`ifdef PIXEL_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] r_tcnt;
   logic          r_err;
   assign err = r_err;
`else
   wire [31:0] w_unused_timeout = 32'(TIMEOUT_CYC);
   assign err = 1'b0;
`endif

   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_row        <= '0;
         r_col        <= '0;
         r_rows       <= '0;
         r_cols       <= '0;
         r_data       <= '0;
         r_resp       <= 1'b0;
         r_incp       <= 1'b0;
         r_resv       <= 1'b0;
         r_incv       <= 1'b0;
         r_inphi      <= 1'b0;
         r_adc_start  <= 1'b0;
         r_fifo_wren  <= 1'b0;
         r_fifo_wdata <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef PIXEL_SEQ_TIMEOUT_EN
         r_tcnt       <= '0;
         r_err        <= 1'b0;
`endif
      end else begin
         r_done      <= 1'b0;
         r_adc_start <= 1'b0;
         r_fifo_wren <= 1'b0;
         // abort outranks every other event, including a pending write or timeout
         if (abort && r_state != S_IDLE) begin
            r_state <= S_IDLE;
            r_resp  <= 1'b0;
            r_incp  <= 1'b0;
            r_resv  <= 1'b0;
            r_incv  <= 1'b0;
            r_inphi <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     if (rows != 8'd0 && cols != 8'd0) begin
                        r_rows  <= rows;
                        r_cols  <= cols;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_cnt   <= '0;
                        r_resv  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_VRST;
`ifdef PIXEL_SEQ_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                     end else begin
                        r_done <= 1'b1;
                     end
                  end
               end
               S_VRST: begin
                  if (r_cnt == PW_LAST) begin
                     r_cnt   <= '0;
                     r_resv  <= 1'b0;
                     r_resp  <= 1'b1;
                     r_col   <= '0;
                     r_state <= S_PRST;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               S_PRST: begin
                  if (r_cnt == PW_LAST) begin
                     r_cnt   <= '0;
                     r_resp  <= 1'b0;
                     r_inphi <= 1'b1;
                     r_state <= S_SETTLE;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               S_SETTLE: begin
                  if (r_cnt == SETTLE_LAST) begin
                     r_cnt       <= '0;
                     r_adc_start <= 1'b1;
                     r_state     <= S_CONV;
`ifdef PIXEL_SEQ_TIMEOUT_EN
                     r_tcnt      <= '0;
`endif
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               S_CONV: begin
                  if (adc_done) begin
                     r_data  <= adc_data;
                     r_state <= S_WRITE;
`ifdef PIXEL_SEQ_TIMEOUT_EN
                  end else if (r_tcnt == T_LAST) begin
                     r_err   <= 1'b1;
                     r_inphi <= 1'b0;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_tcnt <= r_tcnt + TW'(1);
`endif
                  end
               end
               S_WRITE: begin
                  if (!fifo_full) begin
                     r_fifo_wren  <= 1'b1;
                     r_fifo_wdata <= r_data;
                     r_inphi      <= 1'b0;
                     r_cnt        <= '0;
                     if (r_col != r_cols - 8'd1) begin
                        r_incp  <= 1'b1;
                        r_state <= S_INCP;
                     end else if (r_row != r_rows - 8'd1) begin
                        r_incv  <= 1'b1;
                        r_state <= S_INCV;
                     end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                     end
                  end
               end
               S_INCP: begin
                  if (r_cnt == PW_LAST) begin
                     r_cnt   <= '0;
                     r_incp  <= 1'b0;
                     r_col   <= r_col + 8'd1;
                     r_inphi <= 1'b1;
                     r_state <= S_SETTLE;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               S_INCV: begin
                  if (r_cnt == PW_LAST) begin
                     r_cnt   <= '0;
                     r_incv  <= 1'b0;
                     r_row   <= r_row + 8'd1;
                     r_col   <= '0;
                     r_resp  <= 1'b1;
                     r_state <= S_PRST;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign resp       = r_resp;
   assign incp       = r_incp;
   assign resv       = r_resv;
   assign incv       = r_incv;
   assign inphi      = r_inphi;
   assign adc_start  = r_adc_start;
   assign fifo_wren  = r_fifo_wren;
   assign fifo_wdata = r_fifo_wdata;
   assign busy       = r_busy;
   assign done       = r_done;
endmodule

// File: doc/pixel_seq.md
PIXEL_SEQ -- requirements
Module: pixel_seq

Interface
REQ-001 Parameter PULSE_W, default 2: width in clocks of every sensor control pulse (resp, incp, resv, incv); legal 1..255.
REQ-002 Parameter SETTLE_CYC, default 4: clocks between pixel select and ADC start; legal 1..255.
REQ-003 Parameter TIMEOUT_CYC, default 1000: ADC conversion timeout in clocks (used only under REQ-027).
REQ-004 CLK50  in  1  sole clock, all logic rising-edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  request one frame capture; level-sampled in IDLE.
REQ-007 abort  in  1  terminate the current frame.
REQ-008 rows, cols  in  8 each  frame dimensions, latched at start acceptance.
REQ-009 adc_done  in  1  conversion complete strobe.
REQ-010 adc_data  in  10  conversion result, valid while adc_done=1.
REQ-011 fifo_full  in  1  pixel FIFO full.
REQ-012 resp, incp, resv, incv, inphi  out  1 each  sensor row/column pointer controls.
REQ-013 adc_start  out  1  one-clock conversion request.
REQ-014 fifo_wren  out  1; fifo_wdata  out  10  pixel write.
REQ-015 busy  out  1; done  out  1 (one-clock frame-complete pulse); err  out  1 (sticky conversion timeout).

Function
REQ-016 States: IDLE, VRST, PRST, SETTLE, CONV, WRITE, INCP, INCV; all outputs registered.
REQ-017 IDLE: start=1 with rows!=0 and cols!=0 latches dims, clears row/col counters and err, enters VRST; busy=1 from the next clock until return to IDLE.
REQ-018 start=1 with rows=0 or cols=0: no sensor pulses, done=1 exactly one clock later, stay IDLE.
REQ-019 VRST: resv high PULSE_W clocks, then PRST; PRST: resp high PULSE_W clocks, col=0, then SETTLE.
REQ-020 inphi high throughout SETTLE, CONV, WRITE; SETTLE lasts SETTLE_CYC clocks, then adc_start=1 for one clock on entry to CONV.
REQ-021 CONV: on adc_done=1 capture adc_data, go WRITE; adc_done outside CONV ignored.
REQ-022 WRITE: if fifo_full=1 hold data, fifo_wren=0, remain; when fifo_full=0 assert fifo_wren one clock with captured data; exactly one write per pixel, none dropped or duplicated.
REQ-023 After write: col<cols-1 -> INCP (incp PULSE_W clocks, col+1, SETTLE); else row<rows-1 -> INCV (incv PULSE_W clocks, row+1, PRST); else done=1 one clock, IDLE.
REQ-024 Pixel write order row-major, row 0 column 0 first; counters 8-bit, no wrap since limits <=255.
REQ-025 start while busy ignored; dims changes while busy ignored.
REQ-026 abort=1 in any non-IDLE state: next clock IDLE, all pulse outputs and fifo_wren 0, no done, err unchanged; abort has priority over every other event that clock.

Configuration
REQ-027 Macro PIXEL_SEQ_TIMEOUT_EN defined: cycle counter in CONV; TIMEOUT_CYC clocks without adc_done sets err=1, returns to IDLE without done or write; adc_done on the expiring clock wins (no error). Macro undefined: CONV waits indefinitely, err tied 0, no counter logic.

Reset
REQ-028 RST=1 forces IDLE immediately and asynchronously; all outputs 0, counters and captured data 0, err 0; applies mid-frame identically.
REQ-029 First start accepted on the first rising edge after RST deasserts.

Verification
REQ-030 rows=2, cols=3, fifo_full=0, ADC returns 1..6 -> 6 writes in order 1..6, resv x1, resp x2, incp x4, incv x1, done x1, busy low after done.
REQ-031 fifo_full held 20 clocks at pixel 2 -> fifo_wren low throughout, data held, single write after release, total 6 writes.
REQ-032 rows=0, cols=5, start -> done one clock later, no resv/resp/adc_start.
REQ-033 abort during CONV of pixel 3 -> IDLE next clock, no further writes, no done; new start runs full frame.
REQ-034 PIXEL_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, adc_done withheld -> err=1 after 16 CONV clocks, IDLE, no done; next start clears err.
REQ-035 RST pulse mid-INCP -> all outputs 0 within the same clock period, busy 0, counters 0.
